// File: rtl/jeff_serial_pkg.sv
// Shared types and constants for the serial byte loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jeff_serial_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam bit MSB_FIRST_C = 1'b1;
  localparam bit LSB_FIRST_C = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

endpackage

// File: rtl/jeff_bit_counter.sv
// Mod-WIDTH up-counter with sync clear and terminal-count flag.
// Latency: cnt updates on the enabling edge; tc is combinational from cnt.
// Backpressure: none; en simply holds the count when low.
//   clk, rst_n : clock, async active-low reset
//   sclr       : sync clear (wins over en)
//   en         : advance by one (wraps WIDTH-1 -> 0)
//   cnt        : current count 0..WIDTH-1
//   tc         : cnt == WIDTH-1
module jeff_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclr,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     tc
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sclr) begin
      cnt <= '0;
    end else if (en) begin
      // Explicit wrap so non-power-of-two widths never reach WIDTH.
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jeff_serial_byte_loader.sv
// Serial-in, parallel-out word assembler feeding a clock-enable register.
// Latency: par_out/load_en registered on the edge accepting the last bit.
// Backpressure: none; bit_valid low holds state, 1 bit/cycle sustained.
//   clk, rst_n : clock, async active-low reset
//   sclr       : sync abort of partial word (par_out kept)
//   bit_in     : serial data, accepted when bit_valid is high
//   par_out    : last complete word
//   load_en    : one-cycle pulse when par_out was just updated
//   busy       : partial word held (bit_cnt != 0)
//   bit_cnt    : bits in current partial word
module jeff_serial_byte_loader
  import jeff_serial_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_C
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclr,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic [WIDTH-1:0]         par_out,
  output logic                     load_en,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             accept;
  logic             tc;

  // sclr outranks bit_valid: a bit arriving with sclr is dropped.
  assign accept = bit_valid & ~sclr;
  assign busy   = |bit_cnt;

  jeff_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .sclr  (sclr),
    .en    (accept),
    .cnt   (bit_cnt),
    .tc    (tc)
  );

  always_comb begin
    sr_nxt = sr;
    if (MSB_FIRST) begin
      sr_nxt = {sr[WIDTH-2:0], bit_in};
    end else begin
      sr_nxt = {bit_in, sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      par_out <= '0;
      load_en <= 1'b0;
    end else begin
      load_en <= 1'b0;
      if (sclr) begin
        // Abort: partial word dropped, any same-edge completion discarded.
        sr    <= '0;
        state <= IDLE;
      end else if (bit_valid) begin
        if (tc) begin
          par_out <= sr_nxt;
          sr      <= '0;
          load_en <= 1'b1;
          state   <= LOAD;
        end else begin
          // Covers IDLE, SHIFT and LOAD: a bit in LOAD starts the next word.
          sr    <= sr_nxt;
          state <= SHIFT;
        end
      end else if (state == LOAD) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_jeff_serial_byte_loader.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_jeff_serial_byte_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclr;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] par_m, par_l;
  logic       ld_m, ld_l;
  logic       busy_m, busy_l;
  logic [2:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jeff_serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .bit_in(bit_in), .bit_valid(bit_valid),
    .par_out(par_m), .load_en(ld_m), .busy(busy_m), .bit_cnt(cnt_m)
  );

  jeff_serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .bit_in(bit_in), .bit_valid(bit_valid),
    .par_out(par_l), .load_en(ld_l), .busy(busy_l), .bit_cnt(cnt_l)
  );

  typedef struct {
    logic       sclr;
    logic       vld;
    logic       bin;
    logic [7:0] em;
    logic [7:0] el;
    logic       ld;
    logic [2:0] cnt;
    logic       bsy;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] prev_m = 8'h00;
  logic [7:0] prev_l = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] em, input logic [7:0] el,
                         input logic ld, input logic [2:0] cnt, input logic bsy);
    chk({tag, " par_m"},  32'(par_m),  32'(em));
    chk({tag, " par_l"},  32'(par_l),  32'(el));
    chk({tag, " load_m"}, 32'(ld_m),   32'(ld));
    chk({tag, " load_l"}, 32'(ld_l),   32'(ld));
    chk({tag, " cnt_m"},  32'(cnt_m),  32'(cnt));
    chk({tag, " cnt_l"},  32'(cnt_l),  32'(cnt));
    chk({tag, " busy_m"}, 32'(busy_m), 32'(bsy));
    chk({tag, " busy_l"}, 32'(busy_l), 32'(bsy));
  endtask

  task automatic step(input logic s, input logic v, input logic b);
    sclr      = s;
    bit_valid = v;
    bit_in    = b;
    @(posedge clk);
    #1;
  endtask

  // stim is sent MSB first in time; em/el are the hand-computed words seen by
  // the MSB-first and LSB-first instances. gap inserts an idle cycle per bit.
  task automatic add_word(input logic [7:0] stim, input logic [7:0] em,
                          input logic [7:0] el, input bit gap);
    for (int i = 0; i < 8; i++) begin
      if (gap)
        tbl.push_back('{1'b0, 1'b0, 1'b0, prev_m, prev_l, 1'b0, 3'(i), (i != 0)});
      if (i == 7)
        tbl.push_back('{1'b0, 1'b1, stim[7-i], em, el, 1'b1, 3'd0, 1'b0});
      else
        tbl.push_back('{1'b0, 1'b1, stim[7-i], prev_m, prev_l, 1'b0, 3'(i+1), 1'b1});
    end
    prev_m = em;
    prev_l = el;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; sclr = 1'b0; bit_valid = 1'b0; bit_in = 1'b1;

    // Reset held with bit_valid toggling.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'(i % 2), 1'b1);
      chk_all("reset", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_all("post_reset", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end

    // Table: A5, then 80/01 back-to-back, idle, 3C, C3 continuous, 3C gapped.
    add_word(8'hA5, 8'hA5, 8'hA5, 1'b0);
    add_word(8'h80, 8'h80, 8'h01, 1'b0);
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h80, 8'h01, 1'b0, 3'd0, 1'b0});
    add_word(8'h3C, 8'h3C, 8'h3C, 1'b0);
    add_word(8'hC3, 8'hC3, 8'hC3, 1'b0);
    add_word(8'h3C, 8'h3C, 8'h3C, 1'b1);

    foreach (tbl[i]) begin
      step(tbl[i].sclr, tbl[i].vld, tbl[i].bin);
      chk_all($sformatf("vec%0d", i), tbl[i].em, tbl[i].el, tbl[i].ld, tbl[i].cnt, tbl[i].bsy);
    end

    // Abort after 5 bits, sclr together with bit_valid.
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk_all("abort_fill", 8'h3C, 8'h3C, 1'b0, 3'(i), 1'b1);
    end
    step(1'b1, 1'b1, 1'b1);
    chk_all("abort", 8'h3C, 8'h3C, 1'b0, 3'd0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (i == 8) chk_all("ff_word", 8'hFF, 8'hFF, 1'b1, 3'd0, 1'b0);
      else        chk_all("ff_fill", 8'h3C, 8'h3C, 1'b0, 3'(i), 1'b1);
    end

    // sclr on the completing edge discards the word.
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk_all("sclr_fill", 8'hFF, 8'hFF, 1'b0, 3'(i), 1'b1);
    end
    step(1'b1, 1'b1, 1'b0);
    chk_all("sclr_complete", 8'hFF, 8'hFF, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_all("sclr_after", 8'hFF, 8'hFF, 1'b0, 3'd0, 1'b0);

    // Reset mid-word at bit 4: outputs clear before the next edge.
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk_all("rst_fill", 8'hFF, 8'hFF, 1'b0, 3'(i), 1'b1);
    end
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk_all("reset_hold", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_all("reset_release", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
